// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler
//   Round-robin scheduler sharing one 16:1 bit-select datapath among 16
//   requesters. Each grant lasts at most MAX_HOLD cycles. A source whose
//   hold expires is checked last on re-arbitration, so it yields to any
//   other requester, but a sole requester is re-granted with no gap.
//
// Parameters
//   MAX_HOLD : max consecutive cycles one requester keeps the grant (1..255)
//
// Optional feature
//   MUX16_SCHED_LOCK_EN : adds input `lock`. While granted with lock=1 and
//                         req[s]=1, hold expiry is suppressed and the hold
//                         counter saturates at MAX_HOLD.
//
// Ports
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   req   : request per source (bit i = source i)
//   in    : data bit per source (mux data inputs)
//   s     : registered select, index of the granted source
//   gnt   : registered one-hot grant, zero when idle
//   out   : registered copy of in[s], captured each served grant cycle
//   valid : one-cycle strobe qualifying out
//   busy  : high while in the GRANT state
//   lock  : (MUX16_SCHED_LOCK_EN only) suppress hold expiry
module mux16_rr_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] in,
`ifdef MUX16_SCHED_LOCK_EN
  input  logic        lock,
`endif
  output logic [3:0]  s,
  output logic [15:0] gnt,
  output logic        out,
  output logic        valid,
  output logic        busy
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  s_q, s_d;
  logic [15:0] gnt_q, gnt_d;
  logic        out_q, out_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [4:0]  pick;
  logic        served;
  logic        hold_exp;
  logic        release_now;

  // Returns {found, index} of the first set bit of r scanning start,
  // start+1, ... with wrap. Scanning backwards lets the nearest hit win
  // without an early exit from the loop.
  function automatic logic [4:0] rr_pick(input logic [15:0] r,
                                         input logic [3:0]  start);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = 15; k >= 0; k--) begin
      idx = start + 4'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pick        = '0;
    served      = 1'b0;
    hold_exp    = 1'b0;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[4]) begin
          state_d = GRANT;
          s_d     = pick[3:0];
          gnt_d   = 16'h0001 << pick[3:0];
          cnt_d   = 8'd1;
          busy_d  = 1'b1;
        end
      end

      GRANT: begin
        served = req[s_q];
        if (served) begin
          out_d   = in[s_q];
          valid_d = 1'b1;
        end

        hold_exp = (cnt_q == MAX_HOLD_C);
`ifdef MUX16_SCHED_LOCK_EN
        if (lock && served) hold_exp = 1'b0;
`endif
        release_now = !served || hold_exp;

        if (!release_now) begin
          // Saturate so a locked grant cannot wrap the counter.
          if (cnt_q != MAX_HOLD_C) cnt_d = cnt_q + 8'd1;
        end else begin
          // Search starts after the current owner, so it is checked last.
          ptr_d = s_q + 4'd1;
          pick  = rr_pick(req, s_q + 4'd1);
          if (pick[4]) begin
            s_d   = pick[3:0];
            gnt_d = 16'h0001 << pick[3:0];
            cnt_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s     = s_q;
  assign gnt   = gnt_q;
  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Testbench for mux16_rr_scheduler. Three instances with MAX_HOLD = 4, 2
// and 1 share one stimulus. A cycle-level reference model pushes the
// expected outputs of every instance into a queue as stimulus is applied;
// entries are popped and compared after the clock edge. Directed checks
// with hand-derived constants cover the scenarios of interest.
module tb_mux16_rr_scheduler;

  localparam int NI = 3;
  localparam int HOLD [NI] = '{4, 2, 1};

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] in;
  logic        lock;

  logic [3:0]  s_o     [NI];
  logic [15:0] gnt_o   [NI];
  logic        out_o   [NI];
  logic        valid_o [NI];
  logic        busy_o  [NI];

  mux16_rr_scheduler #(.MAX_HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .in(in),
`ifdef MUX16_SCHED_LOCK_EN
    .lock(lock),
`endif
    .s(s_o[0]), .gnt(gnt_o[0]), .out(out_o[0]), .valid(valid_o[0]), .busy(busy_o[0])
  );

  mux16_rr_scheduler #(.MAX_HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .req(req), .in(in),
`ifdef MUX16_SCHED_LOCK_EN
    .lock(lock),
`endif
    .s(s_o[1]), .gnt(gnt_o[1]), .out(out_o[1]), .valid(valid_o[1]), .busy(busy_o[1])
  );

  mux16_rr_scheduler #(.MAX_HOLD(1)) dut2 (
    .clk(clk), .rst(rst), .req(req), .in(in),
`ifdef MUX16_SCHED_LOCK_EN
    .lock(lock),
`endif
    .s(s_o[2]), .gnt(gnt_o[2]), .out(out_o[2]), .valid(valid_o[2]), .busy(busy_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  bit          m_st    [NI];
  int          m_s     [NI];
  int          m_ptr   [NI];
  int          m_cnt   [NI];
  logic [15:0] m_gnt   [NI];
  bit          m_out   [NI];
  bit          m_valid [NI];
  bit          m_busy  [NI];

  typedef struct packed {
    logic [3:0]  s;
    logic [15:0] gnt;
    logic        out;
    logic        valid;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  function automatic int rr_search(input logic [15:0] r, input int start, output bit found);
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) begin
        found = 1'b1;
        return (start + k) % 16;
      end
    end
    return 0;
  endfunction

  task automatic model_grant(input int k, input int w);
    m_st[k]  = 1'b1;
    m_s[k]   = w;
    m_gnt[k] = 16'h0001 << w;
    m_cnt[k] = 1;
    m_busy[k] = 1'b1;
  endtask

  task automatic model_step(input int k, input int mh);
    int w;
    bit f;
    bit served;
    bit lk;
    bit rel;
    if (rst) begin
      m_st[k] = 0; m_s[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      m_gnt[k] = '0; m_out[k] = 0; m_valid[k] = 0; m_busy[k] = 0;
      return;
    end
    if (!m_st[k]) begin
      m_valid[k] = 1'b0;
      w = rr_search(req, m_ptr[k], f);
      if (f) model_grant(k, w);
    end else begin
      served = req[m_s[k]];
      m_valid[k] = served;
      if (served) m_out[k] = in[m_s[k]];
      lk = 1'b0;
`ifdef MUX16_SCHED_LOCK_EN
      lk = lock && served;
`endif
      rel = !served || (m_cnt[k] == mh && !lk);
      if (!rel) begin
        if (m_cnt[k] < mh) m_cnt[k]++;
      end else begin
        m_ptr[k] = (m_s[k] + 1) % 16;
        w = rr_search(req, m_ptr[k], f);
        if (f) model_grant(k, w);
        else begin
          m_st[k] = 1'b0;
          m_gnt[k] = '0;
          m_busy[k] = 1'b0;
        end
      end
    end
  endtask

  // Apply current inputs for one clock: model predicts, DUT outputs compared.
  task automatic cycle();
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      model_step(k, HOLD[k]);
      e.s     = 4'(m_s[k]);
      e.gnt   = m_gnt[k];
      e.out   = m_out[k];
      e.valid = m_valid[k];
      e.busy  = m_busy[k];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("sb%0d_s", k),     32'(s_o[k]),     32'(e.s));
      chk($sformatf("sb%0d_gnt", k),   32'(gnt_o[k]),   32'(e.gnt));
      chk($sformatf("sb%0d_out", k),   32'(out_o[k]),   32'(e.out));
      chk($sformatf("sb%0d_valid", k), 32'(valid_o[k]), 32'(e.valid));
      chk($sformatf("sb%0d_busy", k),  32'(busy_o[k]),  32'(e.busy));
    end
  endtask

  int ord2 [12] = '{0, 0, 1, 1, 15, 15, 0, 0, 1, 1, 15, 15};
  int ord1 [12] = '{0, 1, 15, 0, 1, 15, 0, 1, 15, 0, 1, 15};

  initial begin
    rst = 1'b1; req = '0; in = '0; lock = 1'b0;

    // Reset state
    cycle(); cycle();
    chk("rst_gnt",   32'(gnt_o[0]),   32'h0);
    chk("rst_s",     32'(s_o[0]),     32'h0);
    chk("rst_valid", 32'(valid_o[0]), 32'h0);
    chk("rst_busy",  32'(busy_o[0]),  32'h0);

    // Single requester, continuous service across hold expiry
    rst = 1'b0; req = 16'h0020; in = 16'h0020;
    cycle();
    chk("single_s",   32'(s_o[0]),   32'd5);
    chk("single_gnt", 32'(gnt_o[0]), 32'h0020);
    chk("single_first_valid", 32'(valid_o[0]), 32'h0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("single_hold_gnt", 32'(gnt_o[0]),   32'h0020);
      chk("single_valid",    32'(valid_o[0]), 32'h1);
      chk("single_out",      32'(out_o[0]),   32'h1);
    end

    // Drop to idle, then reset in the middle of a grant to source 0
    req = '0;
    cycle();
    chk("idle_gnt", 32'(gnt_o[0]), 32'h0);
    req = 16'h0001; in = 16'h0001;
    cycle(); cycle();
    chk("pre_rst_gnt", 32'(gnt_o[0]), 32'h0001);
    rst = 1'b1;
    cycle();
    chk("midrst_gnt",   32'(gnt_o[0]),   32'h0);
    chk("midrst_busy",  32'(busy_o[0]),  32'h0);
    chk("midrst_valid", 32'(valid_o[0]), 32'h0);
    chk("midrst_s",     32'(s_o[0]),     32'h0);

    // Round-robin fairness with wrap 15 -> 0
    rst = 1'b0; req = 16'h8003; in = 16'h8002;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("rr_order_h2", 32'(gnt_o[1]), 32'(16'h0001 << ord2[i]));
      chk("rr_order_h1", 32'(gnt_o[2]), 32'(16'h0001 << ord1[i]));
    end

    // Early release: source 2 drops after one cycle
    rst = 1'b1; req = '0; cycle();
    rst = 1'b0; req = 16'h0014; in = 16'h0000;
    cycle();
    chk("early_first_gnt", 32'(gnt_o[0]), 32'h0004);
    req = 16'h0010;
    cycle();
    chk("early_gnt",   32'(gnt_o[0]),   32'h0010);
    chk("early_s",     32'(s_o[0]),     32'd4);
    chk("early_valid", 32'(valid_o[0]), 32'h0);

    // Data path sweep over all sources
    rst = 1'b1; req = '0; cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req = 16'h0001 << i;
      in  = 16'($urandom);
      in[i] = i[0];
      cycle();
      chk("dp_s", 32'(s_o[0]), 32'(i));
      cycle();
      chk("dp_out",   32'(out_o[0]),   32'(i[0]));
      chk("dp_valid", 32'(valid_o[0]), 32'h1);
    end

`ifdef MUX16_SCHED_LOCK_EN
    // Lock holds the grant past MAX_HOLD until released
    rst = 1'b1; req = '0; cycle();
    rst = 1'b0; req = 16'h0009; in = 16'h0001; lock = 1'b1;
    cycle();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("lock_gnt", 32'(gnt_o[1]), 32'h0001);
    end
    lock = 1'b0;
    cycle();
    chk("unlock_gnt", 32'(gnt_o[1]), 32'h0008);
`endif

    // Random traffic, scoreboard only
    rst = 1'b1; req = '0; cycle();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      in = 16'($urandom);
      lock = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
